// File: rtl/i_cache_pkg.sv
// Shared parameters, address split and FSM encoding for the instruction cache
// and the cache_array storage it is built from.
package i_cache_pkg;

    localparam int unsigned WORD_SIZE      = 16;
    localparam int unsigned NUM_LINES      = 8;
    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned MEM_LATENCY    = 3;
    localparam int unsigned STAT_BITS      = 16;

    localparam int unsigned OFFSET_BITS = $clog2(WORDS_PER_LINE);
    localparam int unsigned INDEX_BITS  = $clog2(NUM_LINES);
    localparam int unsigned TAG_BITS    = WORD_SIZE - INDEX_BITS - OFFSET_BITS;
    localparam int unsigned LAT_BITS    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef logic [WORD_SIZE-1:0]   word_t;
    typedef logic [TAG_BITS-1:0]    tag_t;
    typedef logic [INDEX_BITS-1:0]  index_t;
    typedef logic [OFFSET_BITS-1:0] offset_t;
    typedef logic [STAT_BITS-1:0]   stat_t;

    typedef struct packed {
        tag_t    tag;
        index_t  index;
        offset_t offset;
    } addr_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    function automatic stat_t sat_inc(input stat_t v);
        return (v == '1) ? v : v + stat_t'(1);
    endfunction

endpackage

// File: rtl/i_cache_if.sv
// CPU fetch, memory instruction port and statistics signals of the i_cache.
interface i_cache_if;
    import i_cache_pkg::*;

    logic  cpu_read;
    word_t cpu_address;
    word_t cpu_data;
    logic  cpu_ready;
    logic  flush;
    logic  mem_read;
    word_t mem_address;
    word_t mem_data;
    stat_t stat_hits;
    stat_t stat_misses;

    modport slave (
        input  cpu_read, cpu_address, flush, mem_data,
        output cpu_data, cpu_ready, mem_read, mem_address, stat_hits, stat_misses
    );

    modport master (
        output cpu_read, cpu_address, flush, mem_data,
        input  cpu_data, cpu_ready, mem_read, mem_address, stat_hits, stat_misses
    );

endinterface

// File: rtl/i_cache_cache_array.sv
// Valid/tag/data storage for a direct-mapped cache: combinational read port,
// single-word data write, tag write that also sets valid, per-line and global invalidate.
module cache_array
    import i_cache_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  index_t  rd_index,
    input  offset_t rd_offset,
    output logic    rd_valid,
    output tag_t    rd_tag,
    output word_t   rd_data,
    input  logic    wr_en,
    input  index_t  wr_index,
    input  offset_t wr_offset,
    input  word_t   wr_data,
    input  logic    tag_wr_en,
    input  tag_t    wr_tag,
    input  logic    inval_en,
    input  index_t  inval_index,
    input  logic    flush
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] valid_d;
    tag_t                 tag_q  [NUM_LINES];
    word_t                data_q [NUM_LINES][WORDS_PER_LINE];

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end else begin
            if (inval_en)  valid_d[inval_index] = 1'b0;
            if (tag_wr_en) valid_d[wr_index]    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) valid_q <= '0;
        else       valid_q <= valid_d;
    end

    // Tag and data contents are meaningless while invalid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en)     data_q[wr_index][wr_offset] <= wr_data;
        if (tag_wr_en) tag_q[wr_index]             <= wr_tag;
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index][rd_offset];

endmodule

// File: rtl/i_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, in-order
// whole-line fills on a miss, saturating hit/miss counters.
module i_cache
    import i_cache_pkg::*;
(
    input logic      clk,
    input logic      reset,
    i_cache_if.slave bus
);

    state_e                state_q, state_d;
    index_t                fill_index_q, fill_index_d;
    tag_t                  fill_tag_q, fill_tag_d;
    offset_t               word_q, word_d;
    logic [LAT_BITS-1:0]   lat_q, lat_d;
    logic                  mem_read_q, mem_read_d;
    word_t                 mem_address_q, mem_address_d;
    stat_t                 hits_q, hits_d;
    stat_t                 misses_q, misses_d;

    addr_t   req;
    logic    rd_valid;
    tag_t    rd_tag;
    word_t   rd_data;
    logic    lookup_hit_c;
    logic    ready_c;
    logic    lat_done_c;
    logic    last_word_c;
    logic    wr_en, tag_wr_en, inval_en, arr_flush;

    assign req          = addr_t'(bus.cpu_address);
    assign lookup_hit_c = bus.cpu_read & rd_valid & (rd_tag == req.tag);
    assign ready_c      = (state_q == IDLE) & lookup_hit_c & ~bus.flush;
    assign lat_done_c   = (lat_q == LAT_BITS'(MEM_LATENCY - 1));
    assign last_word_c  = (word_q == offset_t'(WORDS_PER_LINE - 1));

    cache_array u_array (
        .clk         (clk),
        .reset       (reset),
        .rd_index    (req.index),
        .rd_offset   (req.offset),
        .rd_valid    (rd_valid),
        .rd_tag      (rd_tag),
        .rd_data     (rd_data),
        .wr_en       (wr_en),
        .wr_index    (fill_index_q),
        .wr_offset   (word_q),
        .wr_data     (bus.mem_data),
        .tag_wr_en   (tag_wr_en),
        .wr_tag      (fill_tag_q),
        .inval_en    (inval_en),
        .inval_index (req.index),
        .flush       (arr_flush)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.cpu_read && !bus.flush && !lookup_hit_c) state_d = FILL;
            FILL: if (lat_done_c && last_word_c)                    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters, fill bookkeeping and array control; flush in IDLE beats hit and miss.
    always_comb begin
        fill_index_d  = fill_index_q;
        fill_tag_d    = fill_tag_q;
        word_d        = word_q;
        lat_d         = lat_q;
        mem_read_d    = mem_read_q;
        mem_address_d = mem_address_q;
        hits_d        = hits_q;
        misses_d      = misses_q;
        wr_en         = 1'b0;
        tag_wr_en     = 1'b0;
        inval_en      = 1'b0;
        arr_flush     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    arr_flush = 1'b1;
                end else if (ready_c) begin
                    hits_d = sat_inc(hits_q);
                end else if (bus.cpu_read) begin
                    inval_en      = 1'b1;
                    fill_index_d  = req.index;
                    fill_tag_d    = req.tag;
                    word_d        = '0;
                    lat_d         = '0;
                    misses_d      = sat_inc(misses_q);
                    mem_read_d    = 1'b1;
                    mem_address_d = {req.tag, req.index, offset_t'(0)};
                end
            end
            FILL: begin
                if (lat_done_c) begin
                    wr_en  = 1'b1;
                    lat_d  = '0;
                    word_d = word_q + offset_t'(1);
                    if (last_word_c) begin
                        tag_wr_en     = 1'b1;
                        mem_read_d    = 1'b0;
                        mem_address_d = '0;
                    end else begin
                        mem_address_d = mem_address_q + word_t'(1);
                    end
                end else begin
                    lat_d = lat_q + LAT_BITS'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_index_q  <= '0;
            fill_tag_q    <= '0;
            word_q        <= '0;
            lat_q         <= '0;
            mem_read_q    <= 1'b0;
            mem_address_q <= '0;
            hits_q        <= '0;
            misses_q      <= '0;
        end else begin
            fill_index_q  <= fill_index_d;
            fill_tag_q    <= fill_tag_d;
            word_q        <= word_d;
            lat_q         <= lat_d;
            mem_read_q    <= mem_read_d;
            mem_address_q <= mem_address_d;
            hits_q        <= hits_d;
            misses_q      <= misses_d;
        end
    end

    assign bus.cpu_ready   = ready_c;
    assign bus.cpu_data    = ready_c ? rd_data : '0;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_address = mem_address_q;
    assign bus.stat_hits   = hits_q;
    assign bus.stat_misses = misses_q;

endmodule

// File: tb/tb_i_cache.sv
// Bench for i_cache: latency-accurate memory responder plus a line-level
// presence model predicting hit/miss, latency, fetched data and counters.
module tb_i_cache;
    import i_cache_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    i_cache_if bus ();
    i_cache dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    word_t       mem [0:255];
    bit          ref_valid [NUM_LINES];
    tag_t        ref_tag   [NUM_LINES];
    int unsigned ref_hits;
    int unsigned ref_misses;

    localparam int unsigned FILL_CYCLES = WORDS_PER_LINE * MEM_LATENCY;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Memory port: data is only valid on the last cycle of each held request.
    bit    prev_rd   = 1'b0;
    word_t prev_addr = '0;
    int    held      = 0;
    always @(negedge clk) begin
        if (bus.mem_read && prev_rd && bus.mem_address == prev_addr) held = held + 1;
        else held = 0;
        prev_rd   = bus.mem_read;
        prev_addr = bus.mem_address;
        if (bus.mem_read && held == int'(MEM_LATENCY) - 1) bus.mem_data = mem[bus.mem_address[7:0]];
        else bus.mem_data = word_t'($urandom);
    end

    task automatic model_reset();
        for (int i = 0; i < int'(NUM_LINES); i++) ref_valid[i] = 1'b0;
        ref_hits   = 0;
        ref_misses = 0;
    endtask

    task automatic check_stats(input string where);
        check({where, "_stat_hits"},   32'(bus.stat_hits),   ref_hits);
        check({where, "_stat_misses"}, 32'(bus.stat_misses), ref_misses);
    endtask

    // Entered and left at posedge+1; cpu_read stays high on exit for back-to-back fetches.
    task automatic do_read(input word_t addr);
        addr_t a;
        bit    exp_hit;
        word_t base;
        int    cyc;
        int    exp_lat;
        a       = addr_t'(addr);
        exp_hit = ref_valid[a.index] && (ref_tag[a.index] == a.tag);
        base    = addr & ~word_t'(WORDS_PER_LINE - 1);
        exp_lat = exp_hit ? 0 : int'(FILL_CYCLES) + 1;
        cyc     = 0;
        bus.cpu_read    = 1'b1;
        bus.cpu_address = addr;
        forever begin
            @(negedge clk);
            if (bus.cpu_ready) break;
            if (cyc > 0 && cyc <= int'(FILL_CYCLES)) begin
                check("fill_mem_read", 32'(bus.mem_read), 1);
                check("fill_mem_addr", 32'(bus.mem_address),
                      32'(base + word_t'((cyc - 1) / int'(MEM_LATENCY))));
            end else begin
                check("idle_mem_read", 32'(bus.mem_read), 0);
            end
            cyc++;
            if (cyc > 40) begin
                check("ready_timeout", 0, 1);
                break;
            end
            @(posedge clk); #1;
        end
        check("latency", cyc, exp_lat);
        check("cpu_data", 32'(bus.cpu_data), 32'(mem[addr[7:0]]));
        check("hit_mem_read", 32'(bus.mem_read), 0);
        @(posedge clk); #1;
        if (!exp_hit) begin
            ref_misses++;
            ref_valid[a.index] = 1'b1;
            ref_tag[a.index]   = a.tag;
        end
        ref_hits++;
        check_stats("read");
    endtask

    task automatic do_flush(input word_t addr);
        bus.cpu_read    = 1'b1;
        bus.cpu_address = addr;
        bus.flush       = 1'b1;
        @(negedge clk);
        check("flush_ready", 32'(bus.cpu_ready), 0);
        @(posedge clk); #1;
        bus.flush    = 1'b0;
        bus.cpu_read = 1'b0;
        for (int i = 0; i < int'(NUM_LINES); i++) ref_valid[i] = 1'b0;
        check_stats("flush");
    endtask

    task automatic reset_mid_fill(input word_t addr);
        bus.cpu_read    = 1'b1;
        bus.cpu_address = addr;
        repeat (6) @(posedge clk);
        #1;
        reset        = 1'b1;
        bus.cpu_read = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mem_read", 32'(bus.mem_read), 0);
        check("rst_mem_addr", 32'(bus.mem_address), 0);
        check("rst_hits",     32'(bus.stat_hits), 0);
        check("rst_misses",   32'(bus.stat_misses), 0);
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic drop_mid_fill(input word_t addr);
        addr_t a;
        a = addr_t'(addr);
        bus.cpu_read    = 1'b1;
        bus.cpu_address = addr;
        repeat (2) @(posedge clk);
        #1;
        bus.cpu_read = 1'b0;
        repeat (FILL_CYCLES) @(posedge clk);
        #1;
        check("drop_mem_read", 32'(bus.mem_read), 0);
        ref_misses++;
        ref_valid[a.index] = 1'b1;
        ref_tag[a.index]   = a.tag;
        check_stats("drop");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = word_t'($urandom);
        mem[8'h23] = 16'h6000;
        reset           = 1'b1;
        bus.cpu_read    = 1'b0;
        bus.cpu_address = '0;
        bus.flush       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_cpu_ready", 32'(bus.cpu_ready), 0);
        check("reset_cpu_data",  32'(bus.cpu_data), 0);
        check("reset_mem_read",  32'(bus.mem_read), 0);
        check("reset_mem_addr",  32'(bus.mem_address), 0);
        check_stats("reset");
        @(posedge clk); #1;

        // Cold miss then back-to-back hits in the filled line.
        do_read(16'h0023);
        do_read(16'h0020);
        do_read(16'h0021);
        do_read(16'h0022);
        bus.cpu_read = 1'b0;
        check("hits_after_line", 32'(bus.stat_hits), 4);

        // Conflict misses on index 0.
        do_read(16'h0003);
        do_read(16'h0083);
        do_read(16'h0003);
        bus.cpu_read = 1'b0;

        do_flush(16'h0003);
        do_read(16'h0023);
        bus.cpu_read = 1'b0;

        reset_mid_fill(16'h0045);
        do_read(16'h0045);
        bus.cpu_read = 1'b0;

        drop_mid_fill(16'h0064);
        do_read(16'h0065);
        bus.cpu_read = 1'b0;

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                do_flush(word_t'($urandom_range(0, 255)));
            end else begin
                do_read(word_t'($urandom_range(0, 255)));
                if ($urandom_range(0, 3) == 0) begin
                    bus.cpu_read = 1'b0;
                    @(posedge clk); #1;
                end
            end
        end
        bus.cpu_read = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
